// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data load/store,
// with round-robin tie breaking and an abort after TIMEOUT busy cycles.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_mem_read_enable,
  input  logic [31:0] inst_mem_read_addr,
  output logic [31:0] instruction,
  output logic        instruction_kick_up,
  input  logic        data_mem_read_enable,
  input  logic        data_mem_write_enable,
  input  logic [31:0] data_mem_addr,
  input  logic [31:0] data_mem_write_data,
  input  logic [3:0]  data_mem_write_mask,
  output logic [31:0] data_mem_read_data,
  output logic        data_mem_kick_up,
  output logic        mem_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {IDLE, INST_BUSY, DATA_BUSY, RESP} state_e;

  state_e     state_q;
  logic       lastGrantData_q;
  logic       isWrite_q;
  logic [7:0] timeoutCnt_q;

  logic dataReq;
  logic grantData;
  logic grantInst;
  logic timeoutHit;

  // Data wins a tie unless it was the side granted last time.
  always_comb begin
    dataReq    = data_mem_read_enable | data_mem_write_enable;
    grantData  = dataReq && (!inst_mem_read_enable || !lastGrantData_q);
    grantInst  = inst_mem_read_enable && !grantData;
    timeoutHit = (timeoutCnt_q == 8'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= IDLE;
      lastGrantData_q     <= 1'b0;
      isWrite_q           <= 1'b0;
      timeoutCnt_q        <= '0;
      instruction         <= '0;
      instruction_kick_up <= 1'b0;
      data_mem_read_data  <= '0;
      data_mem_kick_up    <= 1'b0;
      mem_enable          <= 1'b0;
      mem_write_enable    <= 1'b0;
      mem_addr            <= '0;
      mem_write_data      <= '0;
      mem_write_mask      <= '0;
      mem_timeout         <= 1'b0;
    end else begin
      instruction_kick_up <= 1'b0;
      data_mem_kick_up    <= 1'b0;
      mem_timeout         <= 1'b0;
      case (state_q)
        IDLE: begin
          timeoutCnt_q <= '0;
          if (grantData) begin
            state_q          <= DATA_BUSY;
            lastGrantData_q  <= 1'b1;
            isWrite_q        <= data_mem_write_enable;
            mem_enable       <= 1'b1;
            mem_write_enable <= data_mem_write_enable;
            mem_addr         <= data_mem_addr;
            mem_write_data   <= data_mem_write_enable ? data_mem_write_data : 32'h0;
            mem_write_mask   <= data_mem_write_enable ? data_mem_write_mask : 4'h0;
          end else if (grantInst) begin
            state_q          <= INST_BUSY;
            lastGrantData_q  <= 1'b0;
            isWrite_q        <= 1'b0;
            mem_enable       <= 1'b1;
            mem_write_enable <= 1'b0;
            mem_addr         <= inst_mem_read_addr;
            mem_write_data   <= '0;
            mem_write_mask   <= '0;
          end
        end
        INST_BUSY, DATA_BUSY: begin
          if (mem_ready || timeoutHit) begin
            state_q          <= RESP;
            mem_enable       <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_addr         <= '0;
            mem_write_data   <= '0;
            mem_write_mask   <= '0;
            mem_timeout      <= !mem_ready;
            // An aborted read returns zero; a completed or aborted store leaves read data alone.
            if (state_q == INST_BUSY) begin
              instruction_kick_up <= 1'b1;
              instruction         <= mem_ready ? mem_read_data : 32'h0;
            end else begin
              data_mem_kick_up <= 1'b1;
              if (!isWrite_q) begin
                data_mem_read_data <= mem_ready ? mem_read_data : 32'h0;
              end
            end
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of BUSY cycles without mem_ready before a request is aborted (legal range 2..255).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 inst_mem_read_enable  in  1  fetch request from IF.
REQ-005 inst_mem_read_addr  in  32  fetch address.
REQ-006 instruction  out  32  fetched word, registered.
REQ-007 instruction_kick_up  out  1  one-cycle fetch-done pulse.
REQ-008 data_mem_read_enable  in  1  load request.
REQ-009 data_mem_write_enable  in  1  store request.
REQ-010 data_mem_addr  in  32  load/store address.
REQ-011 data_mem_write_data  in  32  store data.
REQ-012 data_mem_write_mask  in  4  store byte enables.
REQ-013 data_mem_read_data  out  32  load data, registered.
REQ-014 data_mem_kick_up  out  1  one-cycle load/store-done pulse.
REQ-015 mem_enable, mem_write_enable  out  1 each  shared-port strobes.
REQ-016 mem_addr, mem_write_data  out  32 each; mem_write_mask  out  4.
REQ-017 mem_read_data  in  32; mem_ready  in  1  access-complete from memory.
REQ-018 mem_timeout  out  1  one-cycle pulse, coincident with the aborted requester's kick_up.

Function
REQ-019 States SHALL be IDLE, INST_BUSY, DATA_BUSY, RESP.
REQ-020 Requests SHALL be sampled only at the clock edge ending an IDLE cycle; enables in other states are ignored.
REQ-021 A data request is data_mem_read_enable or data_mem_write_enable; both high SHALL be treated as a write.
REQ-022 Single request in IDLE SHALL go to the matching BUSY state.
REQ-023 Simultaneous requests SHALL use round-robin: grant the side not granted last; last_grant SHALL reset to inst, so data wins the first tie.
REQ-024 On grant, address, write data, mask and write flag SHALL be latched; mem_* outputs SHALL be driven from the latches and held stable throughout BUSY.
REQ-025 mem_enable SHALL be 1 exactly in BUSY states; mem_write_enable SHALL be 1 only in DATA_BUSY for a write; all mem_* outputs SHALL be 0 outside BUSY.
REQ-026 In BUSY with mem_ready=1, the next edge SHALL go to RESP and capture mem_read_data into instruction (inst) or data_mem_read_data (data read); store completion SHALL leave data_mem_read_data unchanged.
REQ-027 In RESP, exactly the granted side's kick_up SHALL be 1 for that one cycle; RESP SHALL go to IDLE unconditionally.
REQ-028 Minimum latency SHALL be: request sampled at edge N, mem_enable high cycle N+1, with mem_ready in that cycle kick_up high cycle N+2, next sample at end of cycle N+3.
REQ-029 A requester holding enable through the cycle after its kick_up SHALL be treated as a new request.
REQ-030 Timeout counter SHALL clear on grant and increment each BUSY cycle without mem_ready; when it reaches TIMEOUT, go to RESP with mem_timeout=1, kick_up to the granted side, read-data output forced to 0.
REQ-031 mem_ready outside BUSY SHALL be ignored.
REQ-032 The ungranted requester SHALL receive no kick_up and its request SHALL be re-arbitrated at the next IDLE.

Reset
REQ-033 Reset SHALL win over every other event in any state: next state IDLE, last_grant=inst, counter=0.
REQ-034 After the reset edge, all outputs SHALL be 0, including instruction and data_mem_read_data.
REQ-035 Reset during BUSY SHALL drop mem_enable at the same edge and SHALL suppress any pending kick_up, even if mem_ready=1 in that cycle.

Verification
REQ-036 Fetch only, addr 0x00000004, mem_ready one cycle after grant, mem_read_data 0x00000013 -> instruction=0x00000013 with instruction_kick_up one cycle, 2 cycles after the sample edge.
REQ-037 Fetch and load requested in the same IDLE cycle out of reset -> data served first, then fetch; repeat both -> order alternates.
REQ-038 Store addr 0x100, data 0xDEADBEEF, mask 0xF -> mem_write_enable=1, mem_write_mask=0xF, address and data stable in every BUSY cycle; data_mem_kick_up pulses once.
REQ-039 mem_ready held 0 with TIMEOUT=16 -> after exactly 16 BUSY cycles mem_timeout and the granted side's kick_up pulse together, read data=0.
REQ-040 Reset asserted in the second BUSY cycle with mem_ready=1 -> no kick_up, all outputs 0 after that edge, and the next tie is granted to data.
REQ-041 Read and write enables both high -> a single write access on the memory port, one data_mem_kick_up, data_mem_read_data unchanged.
